mem_stage_dcache_ctrl: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dcache_tag_data_array.sv | 46 ++++
 rtl/mem_stage_dcache_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_stage_dcache_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and address-slicing constants for the MEM-stage data cache.
package mips_mem_pkg;

  localparam int INDEX_BITS_DEF = 4;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WORD_OFF_BITS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_WR_DONE = 2'd3
  } state_e;

  function automatic int tag_width(input int index_bits);
    return ADDR_W - WORD_OFF_BITS - index_bits;
  endfunction

endpackage

// File: rtl/dcache_tag_data_array.sv
// Direct-mapped line storage: combinational read, posedge write, async valid clear.
module dcache_tag_data_array
  import mips_mem_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_W      = tag_width(INDEX_BITS_DEF)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [DATA_W-1:0]     wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/mem_stage_dcache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, one-word lines,
// write-through, no-write-allocate, with read hit/miss statistics.
module mem_stage_dcache_ctrl
  import mips_mem_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    writeData,
  output logic                 hit,
  output logic [DATA_W-1:0]    readData,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ready,
  output logic [CNT_WIDTH-1:0] read_hits,
  output logic [CNT_WIDTH-1:0] read_misses
);

  localparam int TAG_W   = tag_width(INDEX_BITS);
  localparam int TAG_LSB = INDEX_BITS + WORD_OFF_BITS;

  state_e                 state_q;
  logic                   mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [CNT_WIDTH-1:0]   read_hits_q, read_misses_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag;
  logic                   line_valid, line_hit;
  logic [TAG_W-1:0]       line_tag;
  logic [DATA_W-1:0]      line_data;
  logic                   arr_we;
  logic [DATA_W-1:0]      arr_wdata;
  logic                   unused_addr_bits;

  assign idx              = address[TAG_LSB-1:WORD_OFF_BITS];
  assign tag              = address[ADDR_W-1:TAG_LSB];
  assign unused_addr_bits = ^address[WORD_OFF_BITS-1:0];
  assign line_hit         = line_valid && (line_tag == tag);

  // Refill on a read miss; on a store only refresh a line that already holds the tag.
  assign arr_we    = mem_ready && ((state_q == ST_RD_MISS) ||
                                   ((state_q == ST_WR_THRU) && line_hit));
  assign arr_wdata = (state_q == ST_RD_MISS) ? mem_rdata : writeData;

  dcache_tag_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_idx_i   (idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (arr_we),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      read_hits_q   <= '0;
      read_misses_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (MemRead) begin
            if (line_hit) begin
              read_hits_q <= read_hits_q + CNT_WIDTH'(1);
            end else begin
              read_misses_q <= read_misses_q + CNT_WIDTH'(1);
              state_q       <= ST_RD_MISS;
              mem_req_q     <= 1'b1;
              mem_we_q      <= 1'b0;
              mem_addr_q    <= {address[ADDR_W-1:WORD_OFF_BITS], {WORD_OFF_BITS{1'b0}}};
            end
          end else if (MemWrite) begin
            state_q     <= ST_WR_THRU;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {address[ADDR_W-1:WORD_OFF_BITS], {WORD_OFF_BITS{1'b0}}};
            mem_wdata_q <= writeData;
          end
        end
        ST_RD_MISS: begin
          if (mem_ready) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        ST_WR_THRU: begin
          if (mem_ready) begin
            state_q   <= ST_WR_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        // One advancing cycle retires the store so it is not reissued.
        ST_WR_DONE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hit = 1'b1;
    unique case (state_q)
      ST_IDLE:                hit = MemRead ? line_hit : !MemWrite;
      ST_RD_MISS, ST_WR_THRU: hit = 1'b0;
      ST_WR_DONE:             hit = 1'b1;
      default:                hit = 1'b1;
    endcase
    if (!reset_n) hit = 1'b1;
  end

  assign readData    = ((state_q == ST_IDLE) && MemRead && line_hit) ? line_data : '0;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign read_hits   = read_hits_q;
  assign read_misses = read_misses_q;

endmodule

// File: tb/tb_mem_stage_dcache_ctrl.sv
// Randomized and directed bench for mem_stage_dcache_ctrl against a line-level cache model.
module tb_mem_stage_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic        hit;
  logic [31:0] readData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] read_hits, read_misses;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache lines, statistics and backing memory.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  int          m_hits, m_misses;
  logic [31:0] mem_word [logic [29:0]];

  mem_stage_dcache_ctrl dut (
    .clock(clock), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .writeData(writeData), .hit(hit), .readData(readData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .read_hits(read_hits), .read_misses(read_misses)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (!mem_word.exists(a[31:2])) mem_word[a[31:2]] = $urandom;
    return mem_word[a[31:2]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (read_hits !== 16'(m_hits) || read_misses !== 16'(m_misses)) begin
      n_fail++;
      $display("FAIL %s counters: hits=%0d misses=%0d, required hits=%0d misses=%0d",
               tag, read_hits, read_misses, m_hits, m_misses);
    end
  endtask

  // One pipeline access; starts and ends at a negedge. k = wait cycles before mem_ready.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int k, input string tag);
    int          idx;
    logic [25:0] tg;
    bit          is_hit;
    int          exp_stall, stalls, waited;
    logic [31:0] exp_rdata;
    bit          done;
    idx = int'(a[5:2]);
    tg  = a[31:6];
    check_counters(tag);
    is_hit    = rd && m_valid[idx] && (m_tag[idx] == tg);
    exp_stall = (rd && is_hit) || (!rd && !wr) ? 0 : k + 2;
    exp_rdata = is_hit ? m_data[idx] : get_word(a);

    MemRead = rd; MemWrite = wr; address = a; writeData = wd;
    stalls = 0; waited = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (hit) begin
        done = 1'b1;
        break;
      end
      stalls++;
      mem_ready = 1'b0;
      if (mem_req) begin
        n_checks++;
        if (mem_addr !== {a[31:2], 2'b00} || mem_we !== (wr && !rd) ||
            (wr && !rd && mem_wdata !== wd)) begin
          n_fail++;
          $display("FAIL %s handshake: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                   tag, mem_addr, mem_we, mem_wdata, {a[31:2], 2'b00}, wr && !rd, wd);
        end
        mem_rdata = get_word(a);
        if (waited == k) mem_ready = 1'b1;
        waited++;
      end
      @(negedge clock);
    end
    mem_ready = 1'b0;
    n_checks++;
    if (!done || stalls != exp_stall) begin
      n_fail++;
      $display("FAIL %s stall: completed=%0b cycles=%0d, required cycles=%0d",
               tag, done, stalls, exp_stall);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s mem_req on completion: %b, required 0", tag, mem_req);
    end
    if (rd) begin
      n_checks++;
      if (readData !== exp_rdata) begin
        n_fail++;
        $display("FAIL %s readData: %h, required %h", tag, readData, exp_rdata);
      end
    end

    if (rd) begin
      if (is_hit) m_hits++;
      else begin
        m_misses++;
        m_hits++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = exp_rdata;
      end
    end else if (wr) begin
      mem_word[a[31:2]] = wd;
      if (m_valid[idx] && m_tag[idx] == tg) m_data[idx] = wd;
    end
    @(negedge clock);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (hit !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || readData !== 32'h0 || read_hits !== 16'h0 ||
        read_misses !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: hit=%b req=%b we=%b addr=%h wdata=%h rdata=%h hits=%0d misses=%0d, required hit=1 and all else 0",
               tag, hit, mem_req, mem_we, mem_addr, mem_wdata, readData, read_hits, read_misses);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    mem_word[30'h10]  = 32'hDEADBEEF;
    do_access(1, 0, 32'h40, 32'h0, 3, "rd_miss_40");
    n_checks++;
    if (read_hits !== 16'd1 || read_misses !== 16'd1) begin
      n_fail++;
      $display("FAIL first_miss counters: hits=%0d misses=%0d, required 1/1", read_hits, read_misses);
    end
    do_access(1, 0, 32'h40, 32'h0, 3, "rd_hit_40");
    n_checks++;
    if (read_hits !== 16'd2) begin
      n_fail++;
      $display("FAIL repeat_hit read_hits: %0d, required 2", read_hits);
    end
    do_access(0, 1, 32'h40, 32'h12345678, 2, "wr_40");
    do_access(1, 0, 32'h40, 32'h0, 2, "rd_after_wr_40");
    do_access(1, 0, 32'h440, 32'h0, 1, "conflict_440");
    do_access(1, 0, 32'h40, 32'h0, 1, "reload_40");
    do_access(0, 1, 32'h80, 32'hCAFEF00D, 0, "wr_uncached_80");
    do_access(1, 0, 32'h80, 32'h0, 0, "rd_no_alloc_80");
    do_access(1, 1, 32'h84, 32'h11111111, 2, "rd_wr_both_84");
  endtask

  task automatic test_spurious_ready();
    check_counters("spurious_pre");
    mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (hit !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_ready: hit=%b req=%b, required hit=1 req=0", hit, mem_req);
    end
    mem_ready = 1'b0;
    @(negedge clock);
    check_counters("spurious_post");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int n = 0; n < 60; n++) begin
      a  = {24'h0, 2'($urandom_range(0, 2)), 4'($urandom), 2'($urandom)};
      a[31:30] = 2'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      if (op < 6)      do_access(1, 0, a, $urandom, $urandom_range(0, 4), "rand_rd");
      else if (op < 9) do_access(0, 1, a, $urandom, $urandom_range(0, 4), "rand_wr");
      else             do_access(1, 1, a, $urandom, $urandom_range(0, 4), "rand_both");
    end
    check_counters("rand_end");
  endtask

  task automatic test_back_to_back_hits();
    for (int n = 0; n < 4; n++) do_access(1, 0, 32'h40, 32'h0, 1, "b2b_rd_40");
  endtask

  task automatic test_reset_mid_miss();
    address = 32'h00000C44; MemRead = 1'b1; MemWrite = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_miss setup: req=%b hit=%b, required req=1 hit=0", mem_req, hit);
    end
    #1 reset_n = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("reset_mid_miss");
    MemRead = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_access(1, 0, 32'h40, 32'h0, 1, "post_reset_rd_40");
    check_counters("post_reset_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_spurious_ready();
    test_back_to_back_hits();
    test_random();
    test_reset_mid_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
